// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, sequencer state encoding and ALU function codes.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_ADDI  = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'h7;
    localparam logic [3:0] OP_STORE = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALU function codes equal the opcode so the ALU decodes alu_op directly.
    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_ADD = OP_ADD;
    localparam alu_op_t ALU_SUB = OP_SUB;
    localparam alu_op_t ALU_AND = OP_AND;
    localparam alu_op_t ALU_OR  = OP_OR;
    localparam alu_op_t ALU_XOR = OP_XOR;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // Opcodes A..E are unassigned.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

    // Instructions whose second ALU operand is the immediate field.
    function automatic logic op_uses_imm(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/seq_timeout.sv
// Bus-wait watchdog: counts unacknowledged request cycles and flags the last allowed one.
module seq_timeout #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Clear has priority so a new access always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current cycle is the TIMEOUT_CYCLES-th one waiting when the count reads N-1.
    assign expired = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 8-bit CPU: fetch/decode/execute/mem/write-back over
// one shared memory port, with run/step control, halt, bus timeout and illegal opcodes.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       jump,
    output logic       reg_write,
    output logic       alu_src,
    output logic [3:0] alu_op,
    output logic       mem_to_reg,
    output logic       busy,
    output logic       halted,
    output logic       bus_error,
    output logic       illegal_op
);

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       bus_error_q, bus_error_d;
    logic       illegal_op_q, illegal_op_d;
    logic       wait_st;
    logic       to_expired;
    state_t     boundary_st;

    assign wait_st     = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign boundary_st = run ? ST_FETCH : ST_IDLE;

    // Counter is held at zero outside the wait states and on the ack cycle, so every
    // entry into FETCH or MEM starts a fresh count.
    seq_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (!wait_st || mem_ack),
        .en      (wait_st && !mem_ack),
        .expired (to_expired)
    );

    // State, latched opcode and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NOP;
            bus_error_q  <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            bus_error_q  <= bus_error_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    // Next-state logic; an ack in the expiry cycle wins over the timeout.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        illegal_op_d = illegal_op_q;
        case (state_q)
            ST_IDLE:   if (run || step) state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack)         state_d = ST_DECODE;
                else if (to_expired) state_d = ST_ERROR;
            end
            ST_DECODE: begin
                // Illegal opcodes are recorded and then executed as NOP.
                if (op_is_illegal(opcode)) begin
                    op_d         = OP_NOP;
                    illegal_op_d = 1'b1;
                end else begin
                    op_d = opcode;
                end
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: state_d = ST_WB;
                    OP_LOAD, OP_STORE:                              state_d = ST_MEM;
                    OP_HALT:                                        state_d = ST_HALT;
                    default:                                        state_d = boundary_st;
                endcase
            end
            ST_MEM: begin
                if (mem_ack)         state_d = (op_q == OP_LOAD) ? ST_WB : boundary_st;
                else if (to_expired) state_d = ST_ERROR;
            end
            ST_WB:     state_d = boundary_st;
            default:   state_d = state_q;
        endcase
        bus_error_d = bus_error_q || (state_d == ST_ERROR);
    end

    // Output decode from state and latched opcode; only ir_load/pc_inc look at mem_ack.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        jump       = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 4'h0;
        mem_to_reg = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ack;
                pc_inc  = mem_ack;
            end
            ST_EXEC: begin
                alu_op  = op_q;
                alu_src = op_uses_imm(op_q);
                jump    = (op_q == OP_JMP);
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_STORE);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                alu_op     = op_q;
                mem_to_reg = (op_q == OP_LOAD);
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERROR);
    assign halted     = (state_q == ST_HALT);
    assign bus_error  = bus_error_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: each instruction scenario is walked cycle by cycle
// against hand-derived expectations.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic [3:0] opcode;
    logic       mem_ack;
    logic       ack_tie;
    logic       ack_drv;
    logic       mem_req, mem_we, ir_load, pc_inc, jump, reg_write, alu_src;
    logic [3:0] alu_op;
    logic       mem_to_reg, busy, halted, bus_error, illegal_op;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: either acknowledges every request at once or follows ack_drv.
    assign mem_ack = ack_tie ? mem_req : ack_drv;

    cpu_sequencer #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .opcode     (opcode),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .jump       (jump),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .busy       (busy),
        .halted     (halted),
        .bus_error  (bus_error),
        .illegal_op (illegal_op)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {mem_req, mem_we, ir_load, pc_inc, jump, reg_write, alu_src, alu_op,
                mem_to_reg, busy, halted, bus_error, illegal_op};
    endfunction

    // Leaves the DUT in IDLE just after a falling edge: the current cycle is cycle 0.
    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0;
        ack_tie = 1'b0; ack_drv = 1'b0;
        @(negedge clk); #1;
        check_eq("reset_outs", 32'(all_outs()), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int rw_n, rw_cyc, req_n, we_n;

    initial begin
        // ---- 1: ADD, zero-wait memory ----
        do_reset();
        opcode = 4'h1; ack_tie = 1'b1; run = 1'b1; #1;
        check_eq("t1_idle_busy", busy, 0);
        rw_n = 0; rw_cyc = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            if (c == 1) begin
                check_eq("t1_fetch_req", mem_req, 1);
                check_eq("t1_ir_load", ir_load, 1);
                check_eq("t1_pc_inc", pc_inc, 1);
            end
            if (c == 3) check_eq("t1_exec_alu_op", alu_op, 4'h1);
            if (c == 4) check_eq("t1_wb_m2r", mem_to_reg, 0);
            if (reg_write) begin rw_n++; rw_cyc = c; end
        end
        check_eq("t1_rw_count", rw_n, 1);
        check_eq("t1_rw_cycle", rw_cyc, 4);
        @(negedge clk); #1;
        check_eq("t1_next_fetch", mem_req, 1);

        // ---- 2: LOAD with data ack 3 cycles late ----
        do_reset();
        opcode = 4'h7; run = 1'b1;
        req_n = 0; we_n = 0; rw_n = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ack_drv = (c == 1) || (c == 7);
            if (c == 8) run = 1'b0;
            #1;
            if (c == 3) begin
                check_eq("t2_alu_src", alu_src, 1);
                check_eq("t2_alu_op", alu_op, 4'h7);
            end
            if (c >= 4 && c <= 7) begin req_n += int'(mem_req); we_n += int'(mem_we); end
            if (c <= 7) rw_n += int'(reg_write);
            if (c == 8) begin
                check_eq("t2_wb_rw", reg_write, 1);
                check_eq("t2_wb_m2r", mem_to_reg, 1);
            end
        end
        check_eq("t2_mem_req_cycles", req_n, 4);
        check_eq("t2_mem_we_cycles", we_n, 0);
        check_eq("t2_early_rw", rw_n, 0);
        @(negedge clk); ack_drv = 1'b0; #1;
        check_eq("t2_idle_busy", busy, 0);

        // ---- 3: single step of a STORE ----
        do_reset();
        opcode = 4'h8; ack_tie = 1'b1; step = 1'b1; #1;
        check_eq("t3_c0_busy", busy, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            step = (c == 2);
            #1;
            if (c == 1) check_eq("t3_fetch_req", mem_req, 1);
            if (c == 3) check_eq("t3_alu_src", alu_src, 1);
            if (c == 4) begin
                check_eq("t3_mem_req", mem_req, 1);
                check_eq("t3_mem_we", mem_we, 1);
            end
            if (c == 5) check_eq("t3_idle_busy", busy, 0);
            if (c == 6) check_eq("t3_stray_step_req", mem_req, 0);
        end

        // ---- 4a: fetch never acknowledged ----
        do_reset();
        run = 1'b1; req_n = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); #1;
            req_n += int'(mem_req);
        end
        check_eq("t4_req_cycles", req_n, 16);
        @(negedge clk); #1;
        check_eq("t4_bus_error", bus_error, 1);
        check_eq("t4_err_req", mem_req, 0);
        check_eq("t4_err_busy", busy, 0);
        req_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); ack_drv = 1'b1; step = c[0]; #1;
            req_n += int'(mem_req);
        end
        check_eq("t4_err_absorb_req", req_n, 0);
        check_eq("t4_err_sticky", bus_error, 1);

        // ---- 4b: ack on the 16th cycle beats the timeout ----
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); ack_drv = (c == 16); #1;
        end
        check_eq("t4b_ir_load", ir_load, 1);
        @(negedge clk); ack_drv = 1'b0; #1;
        check_eq("t4b_no_error", bus_error, 0);
        check_eq("t4b_busy", busy, 1);

        // ---- 5a: HALT is absorbing ----
        do_reset();
        opcode = 4'hF; ack_tie = 1'b1; run = 1'b1;
        for (int c = 1; c <= 4; c++) begin @(negedge clk); #1; end
        check_eq("t5_halted", halted, 1);
        check_eq("t5_halt_busy", busy, 0);
        req_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); step = c[0]; #1;
            req_n += int'(mem_req);
        end
        check_eq("t5_halt_no_req", req_n, 0);

        // ---- 5b: illegal opcode B runs as NOP ----
        do_reset();
        opcode = 4'hB; ack_tie = 1'b1; run = 1'b1; rw_n = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            rw_n += int'(reg_write);
            if (c == 3) begin
                check_eq("t5b_illegal", illegal_op, 1);
                check_eq("t5b_alu_op_nop", alu_op, 4'h0);
            end
            if (c == 4) check_eq("t5b_next_fetch", mem_req, 1);
        end
        check_eq("t5b_no_rw", rw_n, 0);

        // ---- 5c: JMP pulses jump for one cycle ----
        do_reset();
        opcode = 4'h9; ack_tie = 1'b1; run = 1'b1; rw_n = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            rw_n += int'(jump);
            if (c == 3) check_eq("t5c_jump", jump, 1);
            if (c == 4) check_eq("t5c_next_fetch", mem_req, 1);
        end
        check_eq("t5c_jump_cycles", rw_n, 1);

        // ---- 6: asynchronous reset during a MEM wait ----
        do_reset();
        opcode = 4'hB; run = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ack_drv = (c == 1) || (c == 4);
            if (c == 4) opcode = 4'h7;
            #1;
        end
        check_eq("t6_mem_wait_req", mem_req, 1);
        check_eq("t6_illegal_set", illegal_op, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("t6_async_outs", 32'(all_outs()), 32'h0);
        @(negedge clk); #1;
        check_eq("t6_held_outs", 32'(all_outs()), 32'h0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
